uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Buffered UART transmitter: accepts bytes on a valid/ready write port, queues them in a small FIFO, and serialises them on `uartTx` as 8N1 frames (optional parity) with a bit period of `DELAY_FRAMES` clocks. It sits next to the existing UART receiver in `top`, driving the `uartTx` pin, so received/processed bytes (echo, status strings) can be sent back to the host without stalling the producer.

## Interface
- `DELAY_FRAMES`, 234, clocks per UART bit (234 = 115200 baud at 27 MHz); minimum 2.
- `FIFO_DEPTH`, 8, FIFO entries; power of two, 2..256.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; one clock, synchronous and active-high.
- `dataIn`  in  8  byte to enqueue.
- `dataValid`  in  1  write strobe; byte is accepted on an edge where `dataValid && ready`.
- `ready`  out  1  FIFO not full; combinational from the registered count.
- `uartTx`  out  1  serial line, idle high.
- `busy`  out  1  high while a frame is on the line (START through STOP).
- `fifoCount`  out  $clog2(FIFO_DEPTH)+1  bytes queued, not counting the frame in flight.

## Operation
- Reset values: `uartTx`=1, `busy`=0, `fifoCount`=0, `ready`=1. FIFO pointers, bit counter and baud counter are cleared; state is IDLE.
- FIFO: circular buffer with wrapping read and write pointers.
  - Push when `dataValid && ready`.
  - Pop when IDLE and count != 0.
  - Push and pop on the same edge leave the count unchanged.
  - A write while full is dropped silently; `fifoCount` stays at FIFO_DEPTH.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: `uartTx`=1. If count != 0, pop the head into the shift register, then go to START.
  - START: `uartTx`=0 for DELAY_FRAMES clocks.
  - DATA: 8 bits, LSB first, each held DELAY_FRAMES clocks. The shift register shifts right at each bit boundary.
  - PARITY (only if configured): 1 bit period.
  - STOP: `uartTx`=1 for DELAY_FRAMES clocks, then go to IDLE.
- Baud counter runs 0..DELAY_FRAMES-1 and reloads at each bit boundary.
- `busy`=1 in every state except IDLE.
- `uartTx` is driven from a register, so it is glitch-free.
- Reset asserted mid-frame aborts the frame: `uartTx` returns to 1 on the next edge and the queued bytes are discarded.

## Timing
- Write accepted on edge E0: `fifoCount` increments after E0. IDLE pops on E1, and `uartTx` falls after E1. Write-to-start-bit latency is therefore 2 clocks from an empty, idle block.
- Frame length: 10·DELAY_FRAMES clocks, or 11·DELAY_FRAMES with parity.
- Back-to-back frames: one IDLE clock between the end of STOP and the next start bit. Frame pitch is 10·DELAY_FRAMES+1 clocks.
- `ready` deasserts in the same cycle `fifoCount` reaches FIFO_DEPTH. It reasserts the cycle after the pop that frees an entry.

## Configuration
- `UART_TX_PARITY_EN`
  - Defined: a PARITY state is inserted after DATA. It transmits even parity (XOR of the 8 data bits) for one bit period, giving 8E1 frames of 11·DELAY_FRAMES clocks.
  - Undefined: no PARITY state and no parity logic; 8N1, 10·DELAY_FRAMES clocks.

## Test plan
All scenarios use DELAY_FRAMES=2 and FIFO_DEPTH=4.
- Single byte: reset, write 0x31 ("1").
  - `uartTx` falls 2 clocks after the write.
  - Sampled mid-bit, the line reads 0,1,0,0,0,1,1,0,0,1 (start, LSB-first data, stop).
  - `busy` is high for exactly 20 clocks.
- Burst: write "1","a","2","B" on consecutive clocks.
  - Four frames decode to 0x31, 0x61, 0x32, 0x42.
  - Start bits are 21 clocks apart.
  - `fifoCount` peaks at 3, because the first byte is popped on the second edge.
- Overflow: hold `dataValid` for 8 clocks with bytes 0x00..0x07 while the first frame is in flight.
  - `ready` drops when the count reaches 4.
  - Exactly 5 bytes are transmitted, 0x00..0x04, in order; the rest are dropped.
- Simultaneous push/pop: write on the same edge IDLE pops the last entry.
  - `fifoCount` is unchanged.
  - Both bytes are sent in order.
- Reset mid-frame: assert `rst` during DATA bit 3.
  - On the next edge: `uartTx`=1, `busy`=0, `fifoCount`=0.
  - No further frames are sent.
- Parity build (`UART_TX_PARITY_EN`): write 0x42.
  - The parity bit is 0 (two ones in the byte).
  - The frame is 22 clocks long.
  - Writing 0x43 gives parity bit 1.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Byte write port for uart_tx_fifo: valid/ready handshake, producer on the master side.
interface uart_tx_fifo_if;
    logic [7:0] dataIn;
    logic       dataValid;
    logic       ready;

    modport master (output dataIn, output dataValid, input ready);
    modport slave  (input dataIn, input dataValid, output ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-queued bytes serialised as 8N1 frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx_fifo #(
    parameter int unsigned DELAY_FRAMES = 234,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    uart_tx_fifo_if.slave                 wr,
    output logic                          uartTx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);

    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned BaudW = $clog2(DELAY_FRAMES);
    localparam logic [BaudW-1:0] BaudMax = BaudW'(DELAY_FRAMES - 1);
    localparam logic [CntW-1:0]  CntFull = CntW'(FIFO_DEPTH);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e            state_q, state_d;
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [7:0]        mem_d [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              push, pop, baud_end;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    assign wr.ready  = (count_q != CntFull);
    assign uartTx    = tx_q;
    assign busy      = (state_q != StIdle);
    assign fifoCount = count_q;

    always_comb begin
        push     = wr.dataValid && wr.ready;
        pop      = (state_q == StIdle) && (count_q != '0);
        baud_end = (baud_q == BaudMax);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        state_d  = state_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        if (push) begin
            mem_d[wr_ptr_q] = wr.dataIn;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end

        // Baud counter only runs while a frame is on the line.
        if (state_q == StIdle || baud_end) begin
            baud_d = '0;
        end else begin
            baud_d = baud_q + BaudW'(1);
        end

        case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (pop) begin
                    shift_d = mem_q[rd_ptr_q];
                    bit_d   = '0;
                    tx_d    = 1'b0;
                    state_d = StStart;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^mem_q[rd_ptr_q];
`endif
                end
            end
            StStart: begin
                if (baud_end) begin
                    tx_d    = shift_q[0];
                    state_d = StData;
                end
            end
            StData: begin
                if (baud_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = StParity;
`else
                        tx_d    = 1'b1;
                        state_d = StStop;
`endif
                    end else begin
                        tx_d = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (baud_end) begin
                    tx_d    = 1'b1;
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (baud_end) begin
                    tx_d    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (DELAY_FRAMES=2, FIFO_DEPTH=4); decodes frames from a line log.
module tb_uart_tx_fifo;

    localparam int D       = 2;
    localparam int Depth   = 4;
    localparam int HistLen = 4096;
`ifdef UART_TX_PARITY_EN
    localparam int FrameBits = 11;
`else
    localparam int FrameBits = 10;
`endif
    localparam int FrameClks = FrameBits * D;
    localparam int Pitch     = FrameClks + 1;

    logic       clk;
    logic       rst;
    logic       uartTx;
    logic       busy;
    logic [2:0] fifoCount;

    uart_tx_fifo_if wr_if ();

    uart_tx_fifo #(
        .DELAY_FRAMES (D),
        .FIFO_DEPTH   (Depth)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr        (wr_if.slave),
        .uartTx    (uartTx),
        .busy      (busy),
        .fifoCount (fifoCount)
    );

    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;
    int   cyc    = 0;
    logic       tx_hist   [HistLen];
    logic       busy_hist [HistLen];
    logic [2:0] cnt_hist  [HistLen];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (cyc < HistLen) begin
            tx_hist[cyc]   = uartTx;
            busy_hist[cyc] = busy;
            cnt_hist[cyc]  = fifoCount;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int find_fall(input int from, input int to);
        for (int i = (from < 1 ? 1 : from); i < to && i < HistLen; i++) begin
            if (tx_hist[i - 1] === 1'b1 && tx_hist[i] === 1'b0) return i;
        end
        return -1;
    endfunction

    function automatic logic [10:0] decode(input int s);
        logic [10:0] f = '0;
        for (int k = 0; k < FrameBits; k++) f[k] = tx_hist[s + D * k + D - 1];
        return f;
    endfunction

    function automatic logic [10:0] exp_frame(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {2'b01, b, 1'b0};
`endif
    endfunction

    function automatic int busy_cycles(input int a, input int b);
        int n = 0;
        for (int i = a; i < b; i++) if (busy_hist[i] === 1'b1) n++;
        return n;
    endfunction

    // Expects n frames, first start at s0, then one every Pitch clocks, then silence.
    task automatic check_train(input string tag, input int s0, input int n,
                               input logic [39:0] bytes);
        int s;
        int prev;
        prev = s0;
        for (int k = 0; k < n; k++) begin
            s = find_fall(k == 0 ? s0 - 2 : prev + FrameClks, cyc);
            check($sformatf("%s_start%0d", tag, k), 32'(s), 32'(s0 + k * Pitch));
            if (s < 0) s = s0 + k * Pitch;
            check($sformatf("%s_frame%0d", tag, k), 32'(decode(s)),
                  32'(exp_frame(bytes[8 * k +: 8])));
            prev = s;
        end
        check($sformatf("%s_no_extra", tag), 32'(find_fall(prev + FrameClks, cyc)), 32'hffffffff);
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_if.dataIn    = b;
        wr_if.dataValid = 1'b1;
    endtask

    int c;
    int s;
    int peak;

    initial begin
        rst             = 1'b1;
        wr_if.dataIn    = 8'h00;
        wr_if.dataValid = 1'b0;
        ticks(2);
        check("rst_tx", 32'(uartTx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(fifoCount), 32'd0);
        check("rst_ready", 32'(wr_if.ready), 32'd1);
        rst = 1'b0;
        ticks(2);

        // Single byte
        c = cyc;
        write_byte(8'h31);
        tick();
        wr_if.dataValid = 1'b0;
        check("single_count", 32'(fifoCount), 32'd1);
        ticks(FrameClks + 10);
        check_train("single", c + 2, 1, 40'h31);
        check("single_busy", 32'(busy_cycles(c, c + FrameClks + 8)), 32'(FrameClks));

        // Burst of four on consecutive clocks
        c = cyc;
        write_byte(8'h31); tick();
        write_byte(8'h61); tick();
        write_byte(8'h32); tick();
        write_byte(8'h42); tick();
        wr_if.dataValid = 1'b0;
        ticks(4 * Pitch + 10);
        peak = 0;
        for (int i = c; i < c + 10; i++) if (int'(cnt_hist[i]) > peak) peak = int'(cnt_hist[i]);
        check("burst_peak", 32'(peak), 32'd3);
        check_train("burst", c + 2, 4, 40'h00_42_32_61_31);

        // Overflow: eight writes held against a 4-deep FIFO
        c = cyc;
        for (int i = 0; i < 8; i++) begin
            write_byte(8'(i));
            tick();
            if (i == 3) check("ovf_ready_before", 32'(wr_if.ready), 32'd1);
            if (i == 4) begin
                check("ovf_ready_full", 32'(wr_if.ready), 32'd0);
                check("ovf_count_full", 32'(fifoCount), 32'd4);
            end
            if (i == 7) check("ovf_count_hold", 32'(fifoCount), 32'd4);
        end
        wr_if.dataValid = 1'b0;
        ticks(5 * Pitch + 20);
        check_train("ovf", c + 2, 5, 40'h04_03_02_01_00);

        // Push on the same edge IDLE pops the last entry
        c = cyc;
        write_byte(8'hA5); tick();
        write_byte(8'h5A); tick();
        wr_if.dataValid = 1'b0;
        ticks(Pitch - 1);
        check("simul_count_before", 32'(fifoCount), 32'd1);
        write_byte(8'hC3); tick();
        wr_if.dataValid = 1'b0;
        check("simul_count_after", 32'(fifoCount), 32'd1);
        check("simul_busy", 32'(busy), 32'd1);
        ticks(3 * Pitch + 10);
        check_train("simul", c + 2, 3, 40'h00_00_C3_5A_A5);

        // Reset during data bit 3 of 0x35 (that bit is 0 on the line)
        c = cyc;
        write_byte(8'h35); tick();
        write_byte(8'h55); tick();
        wr_if.dataValid = 1'b0;
        s = c + 2;
        ticks(s + 4 * D - cyc);
        check("rstmid_line_low", 32'(uartTx), 32'd0);
        check("rstmid_count_before", 32'(fifoCount), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_tx", 32'(uartTx), 32'd1);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_count", 32'(fifoCount), 32'd0);
        ticks(3 * Pitch);
        check("rstmid_silent", 32'(find_fall(s + 4 * D + 1, cyc)), 32'hffffffff);

`ifdef UART_TX_PARITY_EN
        c = cyc;
        write_byte(8'h42); tick();
        write_byte(8'h43); tick();
        wr_if.dataValid = 1'b0;
        ticks(2 * Pitch + 10);
        check_train("par", c + 2, 2, 40'h00_00_00_43_42);
        check("par_bit_42", 32'(tx_hist[c + 2 + 9 * D + D - 1]), 32'd0);
        check("par_bit_43", 32'(tx_hist[c + 2 + Pitch + 9 * D + D - 1]), 32'd1);
        check("par_len", 32'(busy_cycles(c + 2, c + 2 + Pitch)), 32'd22);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
